systolic_feeder: RTL
====================

// Module: systolic_feeder
// PURPOSE
//  Upstream input stage of the 4x4 MAC systolic array. Buffers one NxN activation matrix A
//  and one NxN weight matrix W written over a simple write port. On start, streams them
//  diagonally skewed into the array edge: row lane i feeds a_in of the MAC at row i, col 0;
//  column lane j feeds wt_in of the MAC at row 0, col j. Then flushes zeros so the array drains.
// PARAMETERS
//  N      4   array dimension (lanes per edge)
//  DW     8   element width, matches MAC a_in/wt_in
//  FLUSH  7   zero-padded cycles after last feed slice (array drain time, >=1)
// PORTS
//  clk      in   1       rising-edge clock
//  reset    in   1       asynchronous, active-high reset
//  wr_en    in   1       write strobe for matrix buffers
//  wr_sel   in   1       0 = write A, 1 = write W
//  wr_addr  in   4       element index = row*N + col (log2(N*N) bits)
//  wr_data  in   DW      element value, unsigned
//  start    in   1       begin streaming; sampled only in IDLE
//  busy     out  1       high from start accept until done cycle inclusive
//  done     out  1       one-cycle pulse at end of FLUSH
//  valid    out  1       high while a_out/wt_out carry a feed slice
//  a_out    out  N*DW    lane i at [i*DW +: DW] -> MAC row i a_in
//  wt_out   out  N*DW    lane j at [j*DW +: DW] -> MAC col j wt_in
// BEHAVIOUR
//  Reset: state=IDLE; busy, done, valid = 0; a_out, wt_out = 0; all A/W buffer entries = 0.
//   Reset mid-stream aborts immediately; no done pulse; buffers are cleared.
//  Buffers: A[r][c], W[r][c] written on clk edge when wr_en=1 and state=IDLE.
//   wr_en in any other state is ignored (buffer unchanged).
//   wr_en and start in the same IDLE cycle: write commits; stream uses the updated buffer.
//  FSM: IDLE -> FEED -> FLUSH -> DONE -> IDLE.
//   IDLE:  on edge with start=1: go FEED, t=0. In the same edge, load slice t=0
//          into a_out/wt_out; valid=1, busy=1.
//   FEED:  each edge increments t and loads slice t. After slice t=2N-2 (2N-1 slices),
//          the next edge loads zeros, sets valid=0, enters FLUSH with cnt=FLUSH-1.
//   FLUSH: outputs held 0, valid=0. cnt decrements each edge.
//          At cnt=0 the next edge enters DONE.
//   DONE:  done=1, busy=1 for exactly one cycle. Next edge enters IDLE, busy=0, done=0.
//   start outside IDLE ignored. No back-to-back overlap.
//   Restart is possible the cycle after DONE.
//  Slice t (outputs registered, no combinational path from inputs):
//   lane i a_out  = A[i][t-i] if 0 <= t-i <= N-1, else 0
//   lane j wt_out = W[t-j][j] if 0 <= t-j <= N-1, else 0
//  Widths: t counter >= log2(2N) bits. Data passed unmodified; no arithmetic on elements.
//  Total busy span per run = (2N-1) + FLUSH + 1 cycles (=15 for defaults).
// TESTING
//  1 Reset: assert reset mid-FEED -> same cycle all outputs 0, busy=0; after release,
//    reading back via a new start streams all-zero slices.
//  2 Skew: A[i][k]=4i+k+1, W=identity, start -> t=0: a_out lanes={1,0,0,0},
//    wt lanes={1,0,0,0}; t=3: a lanes={4,7,10,13}, wt lanes={0,0,0,0};
//    t=6: a lanes={0,0,0,16}, wt lanes={0,0,0,1}.
//  3 Timing: start at edge E -> valid high E..E+6, low from E+7; done pulse at edge E+14;
//    busy low at E+15.
//  4 Ignored ops: wr_en with A[0][0]=0xFF during FEED and start during FLUSH ->
//    no effect; the next run still emits A[0][0]=1 and starts only on a new IDLE start.
//  5 Same-cycle: wr_en (A[0][0]=0x55) with start in IDLE -> t=0 lane0 a_out=0x55.
//  6 End-to-end: feeder + 4x4 MAC array with A=4i+k+1, W=identity ->
//    array outputs equal A after drain; max values 0xFF*0xFF*4 fit 24 bits.

Source files
------------

// File: rtl/systolic_feeder.sv
// systolic_feeder: buffers one NxN activation matrix A and one NxN weight
// matrix W, then streams them diagonally skewed into the edge of the MAC
// array. Zeros follow the last slice so the array can drain. A one-cycle
// done pulse closes each run.
module systolic_feeder #(
  parameter int N     = 4,
  parameter int DW    = 8,
  parameter int FLUSH = 7
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic                   wr_sel,
  input  logic [$clog2(N*N)-1:0] wr_addr,
  input  logic [DW-1:0]          wr_data,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic                   valid,
  output logic [N*DW-1:0]        a_out,
  output logic [N*DW-1:0]        wt_out
);

  localparam int AW = $clog2(N*N);
  localparam int TW = $clog2(2*N);
  localparam int CW = (FLUSH > 1) ? $clog2(FLUSH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_FEED, S_FLUSH, S_DONE} state_t;

  state_t          state_q;
  logic [TW-1:0]   t_q;
  logic [CW-1:0]   cnt_q;
  logic            busy_q;
  logic            done_q;
  logic            valid_q;
  logic [N*DW-1:0] aOut_q;
  logic [N*DW-1:0] wtOut_q;

  logic [DW-1:0]   aBuf_q [N*N];
  logic [DW-1:0]   wBuf_q [N*N];
  logic [DW-1:0]   aBuf_d [N*N];
  logic [DW-1:0]   wBuf_d [N*N];

  logic [TW-1:0]   sliceT;
  logic [N*DW-1:0] aSlice;
  logic [N*DW-1:0] wSlice;

  assign busy   = busy_q;
  assign done   = done_q;
  assign valid  = valid_q;
  assign a_out  = aOut_q;
  assign wt_out = wtOut_q;

  // Buffer next state: writes land only while idle; the updated view is also what slice 0 reads, so a write paired with start is streamed.
  always_comb begin
    aBuf_d = aBuf_q;
    wBuf_d = wBuf_q;
    if (state_q == S_IDLE && wr_en) begin
      if (wr_sel) wBuf_d[wr_addr] = wr_data;
      else        aBuf_d[wr_addr] = wr_data;
    end
  end

  // Matrix buffer storage, cleared by reset so an aborted run leaves nothing behind.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N*N; i++) begin
        aBuf_q[i] <= '0;
        wBuf_q[i] <= '0;
      end
    end else begin
      aBuf_q <= aBuf_d;
      wBuf_q <= wBuf_d;
    end
  end

  // Build the skewed slice that the coming edge loads: lane i gets A[i][t-i] and W[t-i][i] while t-i lies inside the matrix.
  always_comb begin
    sliceT = (state_q == S_IDLE) ? '0 : t_q + 1'b1;
    aSlice = '0;
    wSlice = '0;
    for (int i = 0; i < N; i++) begin
      if (int'(sliceT) >= i && int'(sliceT) - i < N) begin
        aSlice[i*DW +: DW] = aBuf_d[AW'(i*N + int'(sliceT) - i)];
        wSlice[i*DW +: DW] = wBuf_d[AW'((int'(sliceT) - i)*N + i)];
      end
    end
  end

  // Run sequencer with registered outputs: feed 2N-1 slices, hold zeros for FLUSH cycles, pulse done, return to idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      t_q     <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      aOut_q  <= '0;
      wtOut_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q <= S_FEED;
            t_q     <= '0;
            busy_q  <= 1'b1;
            valid_q <= 1'b1;
            aOut_q  <= aSlice;
            wtOut_q <= wSlice;
          end
        end
        S_FEED: begin
          if (t_q == TW'(2*N-2)) begin
            state_q <= S_FLUSH;
            cnt_q   <= CW'(FLUSH-1);
            valid_q <= 1'b0;
            aOut_q  <= '0;
            wtOut_q <= '0;
          end else begin
            t_q     <= t_q + 1'b1;
            aOut_q  <= aSlice;
            wtOut_q <= wSlice;
          end
        end
        S_FLUSH: begin
          if (cnt_q == '0) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule
